// File: rtl/bcp_pkg.sv
// rtl/bcp_pkg.sv - shared constants and state type for the implication scheduler
package bcp_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    ISSUE,
    FLUSH
  } sched_state_t;
endpackage

// File: rtl/bcp_prio_sel.sv
// rtl/bcp_prio_sel.sv - fixed-priority selector, highest set index wins
module bcp_prio_sel
  import bcp_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |req;
    // Ascending scan so the last (highest) set bit overwrites lower ones.
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bcp_implication_scheduler.sv
// rtl/bcp_implication_scheduler.sv - captures clause-unit implications and offers them one at a time
module bcp_implication_scheduler
  import bcp_pkg::*;
#(
  parameter int LIT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         req_valid,
  input  logic [8*LIT_W-1:0] req_lit,
  output logic [7:0]         req_ack,
  output logic               imp_valid,
  output logic [LIT_W-1:0]   imp_lit,
  output logic [2:0]         imp_src,
  input  logic               imp_ready,
  input  logic               conflict,
  output logic               busy
);

  sched_state_t     state, state_nxt;
  logic [N_REQ-1:0] pending, capture, clr_mask, remaining;
  logic [LIT_W-1:0] slot [N_REQ];
  logic [IDX_W-1:0] sel_idx, prio_idx;
  logic             prio_any, accept;

  bcp_prio_sel u_prio_sel (
    .req (pending),
    .idx (prio_idx),
    .any (prio_any)
  );

  always_comb begin
    capture   = '0;
    clr_mask  = '0;
    accept    = 1'b0;
    state_nxt = state;

    // A slot that is still pending (even if it is being cleared now) is not reloaded.
    if (!conflict && state != FLUSH) capture = req_valid & ~pending;

    if (state == ISSUE && imp_ready && !conflict) begin
      accept            = 1'b1;
      clr_mask[sel_idx] = 1'b1;
    end
    remaining = pending & ~clr_mask;

    case (state)
      IDLE:   if (|pending) state_nxt = SELECT;
      SELECT: state_nxt = prio_any ? ISSUE : IDLE;
      ISSUE:  if (accept) state_nxt = (|remaining) ? SELECT : IDLE;
      FLUSH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (conflict) state_nxt = FLUSH;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      sel_idx <= '0;
      req_ack <= '0;
      for (int i = 0; i < N_REQ; i++) slot[i] <= '0;
    end else begin
      state   <= state_nxt;
      pending <= conflict ? '0 : (remaining | capture);
      req_ack <= capture;
      if (state == SELECT) sel_idx <= prio_idx;
      for (int i = 0; i < N_REQ; i++) begin
        if (capture[i]) slot[i] <= req_lit[i*LIT_W +: LIT_W];
      end
    end
  end

  // Slot under offer cannot be rewritten while its pending bit is set, so the offer is stable.
  assign imp_valid = (state == ISSUE);
  assign imp_lit   = imp_valid ? slot[sel_idx] : '0;
  assign imp_src   = imp_valid ? sel_idx : '0;
  assign busy      = (|pending) || (state != IDLE);

endmodule

// File: tb/tb_bcp_implication_scheduler.sv
// tb/tb_bcp_implication_scheduler.sv - scoreboard bench for the implication scheduler
module tb_bcp_implication_scheduler;

  typedef struct packed {
    logic [7:0] lit;
    logic [2:0] src;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  req_valid;
  logic [63:0] req_lit;
  logic [7:0]  req_ack;
  logic        imp_valid;
  logic [7:0]  imp_lit;
  logic [2:0]  imp_src;
  logic        imp_ready;
  logic        conflict;
  logic        busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  bcp_implication_scheduler #(.LIT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_lit   (req_lit),
    .req_ack   (req_ack),
    .imp_valid (imp_valid),
    .imp_lit   (imp_lit),
    .imp_src   (imp_src),
    .imp_ready (imp_ready),
    .conflict  (conflict),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every accepted offer must match the next scoreboard entry.
  always @(negedge clock) begin
    if (!reset && imp_valid && imp_ready && !conflict) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_issue: got src %0d lit %0h expected none", imp_src, imp_lit);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_lit", 32'(imp_lit), 32'(e.lit));
        chk("sb_src", 32'(imp_src), 32'(e.src));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lit(input int i, input logic [7:0] v);
    req_lit[i*8 +: 8] = v;
  endtask

  task automatic push(input logic [7:0] lit, input logic [2:0] src);
    exp_t e;
    e.lit = lit;
    e.src = src;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (!busy && exp_q.size() == 0) done = 1;
      else tick();
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_lit   = '0;
    imp_ready = 1'b1;
    conflict  = 1'b0;
    tick();
    tick();
    chk("rst_ack", 32'(req_ack), 32'h0);
    chk("rst_valid", 32'(imp_valid), 32'h0);
    chk("rst_lit", 32'(imp_lit), 32'h0);
    chk("rst_src", 32'(imp_src), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();

    // Single request: latency ack@1, SELECT@2, issue@3
    set_lit(2, 8'h2A);
    req_valid = 8'h04;
    push(8'h2A, 3'd2);
    tick();
    chk("s1_ack", 32'(req_ack), 32'h04);
    req_valid = '0;
    tick();
    chk("s1_sel_novalid", 32'(imp_valid), 32'h0);
    chk("s1_ack_pulse", 32'(req_ack), 32'h0);
    tick();
    chk("s1_valid", 32'(imp_valid), 32'h1);
    chk("s1_lit", 32'(imp_lit), 32'h2A);
    chk("s1_src", 32'(imp_src), 32'h2);
    tick();
    chk("s1_busy_after", 32'(busy), 32'h0);
    chk("s1_lit_zero", 32'(imp_lit), 32'h0);

    // Simultaneous requesters 7 and 0: priority order 7 then 0
    set_lit(7, 8'h77);
    set_lit(0, 8'h10);
    req_valid = 8'h81;
    push(8'h77, 3'd7);
    push(8'h10, 3'd0);
    tick();
    chk("s2_ack", 32'(req_ack), 32'h81);
    req_valid = '0;
    wait_idle("s2_drain");

    // Backpressure: offer stable, late higher-index request waits its turn
    imp_ready = 1'b0;
    set_lit(3, 8'h33);
    set_lit(6, 8'h66);
    req_valid = 8'h08;
    push(8'h33, 3'd3);
    push(8'h66, 3'd6);
    tick();
    chk("s3_ack3", 32'(req_ack), 32'h08);
    req_valid = '0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("s3_hold_valid", 32'(imp_valid), 32'h1);
      chk("s3_hold_lit", 32'(imp_lit), 32'h33);
      chk("s3_hold_src", 32'(imp_src), 32'h3);
      if (k == 0) req_valid = 8'h40;
      if (k == 1) begin
        chk("s3_ack6", 32'(req_ack), 32'h40);
        req_valid = '0;
      end
      tick();
    end
    imp_ready = 1'b1;
    wait_idle("s3_drain");

    // Conflict during ISSUE with pending 8'h13 beats imp_ready
    set_lit(4, 8'h44);
    set_lit(1, 8'h11);
    set_lit(0, 8'h01);
    req_valid = 8'h13;
    tick();
    chk("s4_ack", 32'(req_ack), 32'h13);
    req_valid = '0;
    tick();
    tick();
    chk("s4_issue_src", 32'(imp_src), 32'h4);
    conflict = 1'b1;
    tick();
    conflict = 1'b0;
    chk("s4_flush_valid", 32'(imp_valid), 32'h0);
    chk("s4_flush_busy", 32'(busy), 32'h1);
    chk("s4_flush_ack", 32'(req_ack), 32'h0);
    tick();
    chk("s4_idle_busy", 32'(busy), 32'h0);
    tick();
    chk("s4_no_reissue", 32'(imp_valid), 32'h0);

    // Requester 5 re-asserts in the cycle its entry is accepted
    set_lit(5, 8'h55);
    req_valid = 8'h20;
    push(8'h55, 3'd5);
    push(8'h56, 3'd5);
    tick();
    chk("s5_ack1", 32'(req_ack), 32'h20);
    req_valid = '0;
    tick();
    tick();
    chk("s5_issue1", 32'(imp_valid), 32'h1);
    set_lit(5, 8'h56);
    req_valid = 8'h20;
    tick();
    chk("s5_no_same_cycle_ack", 32'(req_ack), 32'h0);
    tick();
    chk("s5_ack2", 32'(req_ack), 32'h20);
    req_valid = '0;
    wait_idle("s5_drain");

    // Reset during ISSUE with all requesters pending
    imp_ready = 1'b0;
    for (int i = 0; i < 8; i++) set_lit(i, 8'hA0 + 8'(i));
    req_valid = 8'hFF;
    tick();
    chk("s6_ack", 32'(req_ack), 32'hFF);
    req_valid = '0;
    tick();
    tick();
    chk("s6_issue_src", 32'(imp_src), 32'h7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    imp_ready = 1'b1;
    chk("s6_valid", 32'(imp_valid), 32'h0);
    chk("s6_lit", 32'(imp_lit), 32'h0);
    chk("s6_src", 32'(imp_src), 32'h0);
    chk("s6_ack_rst", 32'(req_ack), 32'h0);
    chk("s6_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("s6_quiet_valid", 32'(imp_valid), 32'h0);
      chk("s6_quiet_ack", 32'(req_ack), 32'h0);
    end

    // Fresh request after reset still works
    set_lit(1, 8'h5A);
    req_valid = 8'h02;
    push(8'h5A, 3'd1);
    tick();
    chk("s7_ack", 32'(req_ack), 32'h02);
    req_valid = '0;
    wait_idle("s7_drain");
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcp_implication_scheduler.md
BCP_IMPLICATION_SCHEDULER -- requirements
Module: bcp_implication_scheduler

Interface
REQ-001 The block SHALL have parameter LIT_W, default 8, meaning the literal width in bits.
REQ-002 The block SHALL have parameter N_REQ, fixed at 8, meaning the number of clause-unit requesters.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 8 bits: per-requester implication request.
REQ-006 The block SHALL have port req_lit, input, 8*LIT_W bits: flattened literals; requester i occupies bits [i*LIT_W +: LIT_W].
REQ-007 The block SHALL have port req_ack, output, 8 bits: one-cycle capture pulse per requester.
REQ-008 The block SHALL have port imp_valid, output, 1 bit: implication offered to the BCP engine.
REQ-009 The block SHALL have port imp_lit, output, LIT_W bits: the offered literal.
REQ-010 The block SHALL have port imp_src, output, 3 bits: index of the originating requester.
REQ-011 The block SHALL have port imp_ready, input, 1 bit: BCP engine accepts the offer.
REQ-012 The block SHALL have port conflict, input, 1 bit: flush request from the conflict detector.
REQ-013 The block SHALL have port busy, output, 1 bit: high when pending is nonzero or state is not IDLE.

Function
REQ-014 An 8-bit pending register and eight LIT_W literal slots SHALL hold captured requests.
REQ-015 When req_valid[i]=1, pending[i]=0, conflict=0 and state is not FLUSH, the block SHALL set pending[i], latch slot i, and pulse req_ack[i] in the next cycle.
REQ-016 When req_valid[i]=1 and pending[i]=1, the request SHALL NOT be captured; the requester holds valid until acked.
REQ-017 The FSM SHALL have states IDLE, SELECT, ISSUE and FLUSH.
REQ-018 IDLE SHALL go to SELECT when the registered pending value is nonzero.
REQ-019 SELECT SHALL register the highest set index of pending (bit 7 highest priority) into sel_idx and go to ISSUE.
REQ-020 In ISSUE, imp_valid SHALL be 1, imp_lit SHALL equal slot[sel_idx], and imp_src SHALL equal sel_idx; these SHALL remain stable until imp_ready.
REQ-021 On an ISSUE cycle with imp_ready=1, the block SHALL clear pending[sel_idx], then go to SELECT if other pending bits remain, else to IDLE.
REQ-022 Same-cycle clear of pending[i] and req_valid[i]: the clear SHALL take effect, the request SHALL NOT be captured that cycle, and it SHALL be captured in the following cycle.
REQ-023 A request of higher index arriving during ISSUE SHALL NOT preempt the current offer; it SHALL be considered at the next SELECT.
REQ-024 Latency SHALL be: req_valid sampled at cycle 0 into an empty, idle block gives req_ack at cycle 1, SELECT at cycle 2, and imp_valid at cycle 3.
REQ-025 conflict=1 in any state SHALL clear pending, suppress capture and acks in that cycle, and enter FLUSH; imp_valid SHALL be 0 from the next cycle.
REQ-026 FLUSH SHALL last exactly one cycle, with no captures, then go to IDLE.
REQ-027 conflict has priority over imp_ready in the same cycle: the offer SHALL be discarded and not counted as accepted.
REQ-028 When imp_valid=0, imp_lit and imp_src SHALL be driven to 0.

Reset
REQ-029 On reset, state SHALL be IDLE, and pending, sel_idx, req_ack, imp_valid, imp_lit, imp_src and busy SHALL be 0; literal slots SHALL be cleared to 0.
REQ-030 Reset asserted mid-ISSUE SHALL drop imp_valid in the next cycle and discard all pending requests without acks.

Structure
REQ-031 Package bcp_pkg SHALL hold N_REQ=8, IDX_W=3, and the state enum sched_state_t {IDLE, SELECT, ISSUE, FLUSH}.
REQ-032 Selection SHALL use one combinational sub-module, bcp_prio_sel (8-bit in, 3-bit index plus any-valid out, highest index wins).

Verification
REQ-033 Scenario: single request, req_valid=8'h04, lit=8'h2A, imp_ready tied 1 -> req_ack=8'h04 at cycle 1; imp_valid, imp_lit=8'h2A, imp_src=2 at cycle 3; busy=0 afterwards.
REQ-034 Scenario: simultaneous req_valid=8'h81 -> both acked in one cycle; issue order is imp_src 7 then 0.
REQ-035 Scenario: imp_ready held 0 for 5 cycles, and req 6 arrives while src 3 is offered -> imp_lit/imp_src stable for all 5 cycles; src 3 completes before src 6.
REQ-036 Scenario: conflict pulse during ISSUE with imp_ready=1 and pending=8'h13 -> no acceptance; pending=0 and imp_valid=0 next cycle; one FLUSH cycle, then IDLE.
REQ-037 Scenario: requester 5 re-asserts in the same cycle its entry is accepted -> ack arrives one cycle later and it is issued again.
REQ-038 Scenario: reset during ISSUE with pending=8'hFF -> all outputs 0 next cycle; no acks or imp_valid until new requests arrive.
